// File: rtl/avalon_input_pio_pkg.sv
// ----------------------------------------------------------------------------
// avalon_input_pio_pkg
//   Shared definitions for the Avalon-MM input PIO:
//     - register address map (DATA, RSVD, MASK, EDGE)
//     - edge-detection mode encodings used by the EDGE_TYPE parameter
//     - small helpers for counter sizing and per-bit edge detection
// ----------------------------------------------------------------------------
package avalon_input_pio_pkg;

    // Register map, word addresses on the 2-bit Avalon address bus.
    localparam logic [1:0] ADDR_DATA = 2'd0;
    localparam logic [1:0] ADDR_RSVD = 2'd1;
    localparam logic [1:0] ADDR_MASK = 2'd2;
    localparam logic [1:0] ADDR_EDGE = 2'd3;

    // Which transition of the debounced pin sets its edge_capture bit.
    typedef enum logic [1:0] {
        EDGE_RISING  = 2'd0,
        EDGE_FALLING = 2'd1,
        EDGE_ANY     = 2'd2
    } edge_type_e;

    // Width of a counter that must hold the value n (at least one bit, so a
    // zero-cycle debounce still elaborates cleanly).
    function automatic int cnt_width(input int n);
        return (n < 2) ? 1 : $clog2(n + 1);
    endfunction

    // One-bit edge detector on the debounced level: prev is last cycle's
    // value, cur is this cycle's value.
    function automatic logic edge_hit(input logic prev, input logic cur,
                                      input edge_type_e kind);
        case (kind)
            EDGE_RISING:  return !prev && cur;
            EDGE_FALLING: return prev && !cur;
            default:      return prev ^ cur;
        endcase
    endfunction

endpackage

// File: rtl/avalon_input_pio_input_debouncer.sv
// ----------------------------------------------------------------------------
// input_debouncer
//   One input pin: 2-FF synchronizer followed by a stability counter.
//   The synchronized level must differ from the accepted (stable) level for
//   DEBOUNCE_CYCLES consecutive cycles, plus the accepting cycle, before it
//   is taken as the new stable level. Any cycle where the synchronized level
//   matches the stable level clears the count, so short glitches are lost.
//   DEBOUNCE_CYCLES = 0 bypasses the counter: stable follows the synchronizer
//   one cycle later.
//
// Ports
//   clk      in  1  system clock
//   reset_n  in  1  asynchronous, active-low reset
//   pin      in  1  raw asynchronous pin
//   stable   out 1  synchronized, debounced level (RESET_VALUE in reset)
// ----------------------------------------------------------------------------
module input_debouncer
    import avalon_input_pio_pkg::*;
#(
    parameter int   DEBOUNCE_CYCLES = 50000,
    parameter logic RESET_VALUE     = 1'b1
) (
    input  logic clk,
    input  logic reset_n,
    input  logic pin,
    output logic stable
);

    logic sync_meta;
    logic sync_out;

    // Synchronizer flops reset to the idle pin level so no spurious change is
    // seen when reset is released.
    // NOTE: sequential state is always assigned with <= so every flop samples
    // the pre-edge values of the others; = here would collapse the 2-FF chain.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            sync_meta <= RESET_VALUE;
            sync_out  <= RESET_VALUE;
        end else begin
            sync_meta <= pin;
            sync_out  <= sync_meta;
        end
    end

    generate
        if (DEBOUNCE_CYCLES == 0) begin : g_bypass
            always_ff @(posedge clk or negedge reset_n) begin
                if (!reset_n) begin
                    stable <= RESET_VALUE;
                end else begin
                    stable <= sync_out;
                end
            end
        end else begin : g_count
            localparam int             CW      = cnt_width(DEBOUNCE_CYCLES);
            localparam logic [CW-1:0]  CNT_MAX = CW'(DEBOUNCE_CYCLES);

            logic [CW-1:0] count;

            // The count stops at CNT_MAX: that is the cycle the new level is
            // accepted and the count restarts, so it can never wrap.
            always_ff @(posedge clk or negedge reset_n) begin
                if (!reset_n) begin
                    stable <= RESET_VALUE;
                    count  <= '0;
                end else if (sync_out == stable) begin
                    count  <= '0;
                end else if (count == CNT_MAX) begin
                    stable <= sync_out;
                    count  <= '0;
                end else begin
                    count  <= count + CW'(1);
                end
            end
        end
    endgenerate

endmodule

// File: rtl/avalon_input_pio.sv
// ----------------------------------------------------------------------------
// avalon_input_pio
//   Avalon-MM slave input port for keys/switches. Each pin is synchronized
//   and debounced, the debounced level is edge-detected into a sticky
//   edge_capture register, and a maskable level interrupt is raised while any
//   unmasked capture bit is set.
//
//   Register map (zero wait states, zero read latency):
//     0 DATA  RO     debounced pins
//     1 RSVD  RO     reads 0
//     2 MASK  RW     irq_mask
//     3 EDGE  R/W1C  edge_capture; writing 1 clears a bit
//   Bits at or above WIDTH read 0 and ignore writes.
//
// Ports
//   clk         in   1      system clock
//   reset_n     in   1      asynchronous, active-low reset
//   address     in   2      register select
//   chipselect  in   1      slave select
//   write_n     in   1      active-low write strobe
//   writedata   in   32     write data
//   in_port     in   WIDTH  raw asynchronous pins
//   readdata    out  32     read data, zero-extended
//   irq         out  1      level interrupt request
// ----------------------------------------------------------------------------
module avalon_input_pio
    import avalon_input_pio_pkg::*;
#(
    parameter int               WIDTH           = 4,
    parameter int               DEBOUNCE_CYCLES = 50000,
    parameter int               EDGE_TYPE       = 1,
    parameter logic [WIDTH-1:0] RESET_VALUE     = '1
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic [1:0]       address,
    input  logic             chipselect,
    input  logic             write_n,
    input  logic [31:0]      writedata,
    input  logic [WIDTH-1:0] in_port,
    output logic [31:0]      readdata,
    output logic             irq
);

    localparam edge_type_e EDGE_KIND = edge_type_e'(EDGE_TYPE);

    logic [WIDTH-1:0] stable;        // debounced pin levels (DATA)
    logic [WIDTH-1:0] prev;          // stable delayed one cycle
    logic [WIDTH-1:0] edge_hit_vec;  // edges detected this cycle
    logic [WIDTH-1:0] irq_mask;
    logic [WIDTH-1:0] edge_capture;
    logic [WIDTH-1:0] w1c_clear;
    logic             wr_en;

    // Writedata bits above WIDTH have no destination.
    logic [31:0] unused_writedata;
    assign unused_writedata = writedata;

    // ------------------------------------------------------------------
    // Per-pin synchronizer + debouncer
    // ------------------------------------------------------------------
    for (genvar i = 0; i < WIDTH; i++) begin : g_pin
        input_debouncer #(
            .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
            .RESET_VALUE     (RESET_VALUE[i])
        ) u_debouncer (
            .clk     (clk),
            .reset_n (reset_n),
            .pin     (in_port[i]),
            .stable  (stable[i])
        );
    end

    // ------------------------------------------------------------------
    // Edge detection on the debounced levels
    // ------------------------------------------------------------------
    // NOTE: every variable assigned in always_comb gets a default first, so
    // no path leaves it unassigned and no latch is inferred.
    always_comb begin
        edge_hit_vec = '0;
        for (int i = 0; i < WIDTH; i++) begin
            edge_hit_vec[i] = edge_hit(prev[i], stable[i], EDGE_KIND);
        end
    end

    assign wr_en     = chipselect && !write_n;
    assign w1c_clear = (wr_en && address == ADDR_EDGE) ? writedata[WIDTH-1:0] : '0;

    // ------------------------------------------------------------------
    // Registers
    // ------------------------------------------------------------------
    // prev resets to the same level as the debouncers so that leaving reset
    // never looks like a transition.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            prev         <= RESET_VALUE;
            irq_mask     <= '0;
            edge_capture <= '0;
        end else begin
            prev <= stable;
            if (wr_en && address == ADDR_MASK) begin
                irq_mask <= writedata[WIDTH-1:0];
            end
            // Clear is applied before the OR so a new edge in the same cycle
            // as a W1C keeps the bit set.
            edge_capture <= (edge_capture & ~w1c_clear) | edge_hit_vec;
        end
    end

    // ------------------------------------------------------------------
    // Read mux (combinational, zero read latency) and interrupt
    // ------------------------------------------------------------------
    always_comb begin
        readdata = '0;
        case (address)
            ADDR_DATA: readdata[WIDTH-1:0] = stable;
            ADDR_RSVD: readdata            = '0;
            ADDR_MASK: readdata[WIDTH-1:0] = irq_mask;
            ADDR_EDGE: readdata[WIDTH-1:0] = edge_capture;
        endcase
    end

    assign irq = |(edge_capture & irq_mask);

endmodule

// File: tb/tb_avalon_input_pio.sv
// ----------------------------------------------------------------------------
// tb_avalon_input_pio
//   Bench for avalon_input_pio with WIDTH=4, DEBOUNCE_CYCLES=4, EDGE_TYPE=1
//   (falling), RESET_VALUE=4'hF. A directed vector table and hand-written
//   sequences check fixed expectations; a randomized phase checks against a
//   sliding-window reference model: a pin's DATA level changes once its raw
//   samples taken 2..2+N edges ago all agree on a new value.
// ----------------------------------------------------------------------------
module tb_avalon_input_pio;

    localparam int N = 4;

    logic        clk;
    logic        reset_n;
    logic [1:0]  address;
    logic        chipselect;
    logic        write_n;
    logic [31:0] writedata;
    logic [3:0]  in_port;
    logic [31:0] readdata;
    logic        irq;

    int n_tests = 0;
    int n_fail  = 0;

    avalon_input_pio #(
        .WIDTH           (4),
        .DEBOUNCE_CYCLES (N),
        .EDGE_TYPE       (1),
        .RESET_VALUE     (4'hF)
    ) dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .address    (address),
        .chipselect (chipselect),
        .write_n    (write_n),
        .writedata  (writedata),
        .in_port    (in_port),
        .readdata   (readdata),
        .irq        (irq)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    // ------------------------------------------------------------------
    // Reference model
    // ------------------------------------------------------------------
    logic [3:0] hist [0:N+2];   // hist[j] = raw pins sampled j edges ago
    logic [3:0] m_data;
    logic [3:0] m_prev;
    logic [3:0] m_edge;
    logic [3:0] m_mask;

    task automatic model_reset();
        for (int j = 0; j <= N + 2; j++) hist[j] = 4'hF;
        m_data = 4'hF;
        m_prev = 4'hF;
        m_edge = 4'h0;
        m_mask = 4'h0;
    endtask

    // Advance the model across one clock edge using the inputs now applied.
    task automatic model_step();
        logic [3:0] nd;
        logic [3:0] clr;
        logic       wr;
        for (int j = N + 2; j > 0; j--) hist[j] = hist[j-1];
        hist[0] = in_port;
        nd = m_data;
        for (int b = 0; b < 4; b++) begin
            bit same;
            same = 1'b1;
            for (int j = 3; j <= N + 2; j++) begin
                if (hist[j][b] != hist[2][b]) same = 1'b0;
            end
            if (same) nd[b] = hist[2][b];
        end
        wr  = chipselect && !write_n;
        clr = (wr && address == 2'd3) ? writedata[3:0] : 4'h0;
        if (wr && address == 2'd2) m_mask = writedata[3:0];
        m_edge = (m_edge & ~clr) | (m_prev & ~m_data);
        m_prev = m_data;
        m_data = nd;
    endtask

    function automatic logic [31:0] model_read(input logic [1:0] a);
        case (a)
            2'd0:    return {28'b0, m_data};
            2'd2:    return {28'b0, m_mask};
            2'd3:    return {28'b0, m_edge};
            default: return 32'b0;
        endcase
    endfunction

    // ------------------------------------------------------------------
    // Bench helpers
    // ------------------------------------------------------------------
    task automatic check(input string name, input logic [31:0] act,
                         input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
        end
    endtask

    // One clock edge with the currently applied inputs; returns #1 after it.
    task automatic tick();
        model_step();
        @(posedge clk);
        #1;
    endtask

    task automatic read_check(input logic [1:0] a, input logic [31:0] exp,
                              input string name);
        address    = a;
        chipselect = 1'b1;
        write_n    = 1'b1;
        #1;
        check(name, readdata, exp);
        chipselect = 1'b0;
    endtask

    task automatic check_irq(input logic exp, input string name);
        check(name, {31'b0, irq}, {31'b0, exp});
    endtask

    task automatic bus_write(input logic [1:0] a, input logic [31:0] d);
        address    = a;
        writedata  = d;
        chipselect = 1'b1;
        write_n    = 1'b0;
        tick();
        chipselect = 1'b0;
        write_n    = 1'b1;
    endtask

    task automatic pulse_reset();
        #1 reset_n = 1'b0;
        model_reset();
        #2 reset_n = 1'b1;
    endtask

    // ------------------------------------------------------------------
    // Directed vector table
    // ------------------------------------------------------------------
    typedef struct {
        string      name;
        logic [3:0] pins;
        int         hold;
        logic [3:0] exp_data;
        logic [3:0] exp_edge;
        logic       exp_irq;
    } vec_t;

    vec_t vecs [7];

    initial begin
        // Bit0 goes low at edge k: DATA after k+6, EDGE after k+7.
        vecs[0] = '{"idle",           4'hF,  2, 4'hF, 4'h0, 1'b0};
        vecs[1] = '{"bit0_pending",   4'hE,  6, 4'hF, 4'h0, 1'b0};
        vecs[2] = '{"bit0_data",      4'hE,  1, 4'hE, 4'h0, 1'b0};
        vecs[3] = '{"bit0_edge",      4'hE,  1, 4'hE, 4'h1, 1'b0};
        vecs[4] = '{"glitch_active",  4'hA,  3, 4'hE, 4'h1, 1'b0};
        vecs[5] = '{"glitch_reject",  4'hE, 10, 4'hE, 4'h1, 1'b0};
        vecs[6] = '{"rising_ignored", 4'hF, 10, 4'hF, 4'h1, 1'b0};

        reset_n    = 1'b0;
        in_port    = 4'hF;
        address    = 2'd0;
        chipselect = 1'b0;
        write_n    = 1'b1;
        writedata  = 32'h0;
        model_reset();
        repeat (3) @(posedge clk);
        #1 reset_n = 1'b1;

        // Reset state
        read_check(2'd0, 32'hF, "reset_data");
        read_check(2'd1, 32'h0, "reset_rsvd");
        read_check(2'd2, 32'h0, "reset_mask");
        read_check(2'd3, 32'h0, "reset_edge");
        check_irq(1'b0, "reset_irq");

        // Writes to read-only addresses are ignored.
        bus_write(2'd0, 32'h0);
        bus_write(2'd1, 32'hFFFF_FFFF);
        read_check(2'd0, 32'hF, "data_write_ignored");
        read_check(2'd1, 32'h0, "rsvd_write_ignored");

        foreach (vecs[i]) begin
            in_port = vecs[i].pins;
            repeat (vecs[i].hold) tick();
            read_check(2'd0, {28'b0, vecs[i].exp_data}, {vecs[i].name, "_data"});
            read_check(2'd3, {28'b0, vecs[i].exp_edge}, {vecs[i].name, "_edge"});
            check_irq(vecs[i].exp_irq, {vecs[i].name, "_irq"});
        end

        // Unmasking a pending edge raises irq immediately; W1C drops it.
        bus_write(2'd2, 32'hFFFF_FFF1);
        read_check(2'd2, 32'h1, "mask_readback");
        check_irq(1'b1, "mask_irq_on");
        bus_write(2'd3, 32'h1);
        read_check(2'd3, 32'h0, "w1c_cleared");
        check_irq(1'b0, "w1c_irq_off");

        // New falling edge on bit1 coincides with a W1C of bit1: set wins.
        bus_write(2'd2, 32'h2);
        in_port = 4'hD;
        repeat (7) tick();
        read_check(2'd0, 32'hD, "bit1_data");
        read_check(2'd3, 32'h0, "bit1_edge_not_yet");
        bus_write(2'd3, 32'h2);
        read_check(2'd3, 32'h2, "set_wins_edge");
        check_irq(1'b1, "set_wins_irq");
        bus_write(2'd3, 32'h2);
        read_check(2'd3, 32'h0, "set_wins_cleared");
        check_irq(1'b0, "set_wins_irq_off");
        in_port = 4'hF;
        repeat (10) tick();

        // Reset pulse in the middle of a debounce count.
        bus_write(2'd2, 32'hF);
        in_port = 4'h7;
        repeat (3) tick();
        pulse_reset();
        read_check(2'd0, 32'hF, "midreset_data");
        read_check(2'd2, 32'h0, "midreset_mask");
        read_check(2'd3, 32'h0, "midreset_edge");
        check_irq(1'b0, "midreset_irq");
        in_port = 4'hF;
        repeat (10) tick();
        read_check(2'd0, 32'hF, "post_reset_data");
        read_check(2'd3, 32'h0, "post_reset_no_edge");

        // ------------------------------------------------------------------
        // Randomized phase against the reference model
        // ------------------------------------------------------------------
        for (int i = 0; i < 3000; i++) begin
            int         op;
            logic [1:0] a;
            for (int b = 0; b < 4; b++) begin
                if ($urandom_range(0, 9) == 0) in_port[b] = ~in_port[b];
            end
            op = $urandom_range(0, 9);
            if (op <= 2) begin
                address    = (op == 0) ? 2'd2 : (op == 1) ? 2'd3 : 2'($urandom_range(0, 1));
                writedata  = $urandom;
                chipselect = 1'b1;
                write_n    = 1'b0;
            end
            tick();
            chipselect = 1'b0;
            write_n    = 1'b1;
            a = 2'($urandom_range(0, 3));
            read_check(a, model_read(a), "rand_read");
            check_irq(|(m_edge & m_mask), "rand_irq");
            if ($urandom_range(0, 799) == 0) pulse_reset();
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
